// File: rtl/led_pattern_monitor_if.sv
// LED monitor bus: observed LED pattern plus error clear in, decoded status out.
// master drives led/err_clr; slave (the monitor) drives the status fields.
interface led_pattern_monitor_if #(
    parameter int N_LED = 8
);
    logic [N_LED-1:0] led;
    logic             err_clr;
    logic             dir_valid;
    logic             dir;
    logic             dir_change;
    logic [15:0]      step_count;
    logic             err_pulse;
    logic [1:0]       err_code;
    logic             err_flag;
    logic [7:0]       err_count;

    modport master (
        output led, err_clr,
        input  dir_valid, dir, dir_change, step_count,
        input  err_pulse, err_code, err_flag, err_count
    );

    modport slave (
        input  led, err_clr,
        output dir_valid, dir, dir_change, step_count,
        output err_pulse, err_code, err_flag, err_count
    );
endinterface

// File: rtl/led_pattern_monitor.sv
// Walking-one LED decoder: reports rotation direction/step count, flags pattern, timing and stall errors.
// Latency: all outputs registered, updated at the edge ending the cycle in which led changed.
// Backpressure: none, observe-only. LED_MON_INTERVAL_CHECK_EN enables per-step interval checking.
module led_pattern_monitor #(
    parameter int N_LED       = 8,
    parameter int STEP_CYCLES = 12_500_000,
    parameter int TOL         = 1024,
    parameter int CNT_W       = 24
) (
    input  logic              clk,
    input  logic              rst,
    led_pattern_monitor_if.slave mon
);
    typedef enum logic [1:0] {IDLE, SYNC, TRACK} state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_PAT   = 2'd1;
    localparam logic [1:0] ERR_TIME  = 2'd2;
    localparam logic [1:0] ERR_STALL = 2'd3;
    // cnt holds cycles since the last change minus one, so this value means the
    // next quiet cycle completes an interval of STEP_CYCLES+TOL+1.
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STEP_CYCLES + TOL);

    state_t           state_q, state_d;
    logic [N_LED-1:0] led, led_q, prev_q, prev_d, nxt_same, nxt_opp;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ev;
    logic             dir_valid_q, dir_valid_d, dir_q, dir_d, dir_change_q, dir_change_d;
    logic [15:0]      step_q, step_d;
    logic             err_pulse_q, err_pulse_d, err_flag_q, err_flag_d, err_hit;
    logic [1:0]       err_code_q, err_code_d, err_code_new;
    logic [7:0]       err_count_q, err_count_d;

    function automatic logic [N_LED-1:0] rotl(input logic [N_LED-1:0] v);
        return {v[N_LED-2:0], v[N_LED-1]};
    endfunction

    function automatic logic [N_LED-1:0] rotr(input logic [N_LED-1:0] v);
        return {v[0], v[N_LED-1:1]};
    endfunction

    function automatic logic is_onehot(input logic [N_LED-1:0] v);
        return (v != '0) && ((v & (v - N_LED'(1))) == '0);
    endfunction

    assign led = mon.led;
    assign ev  = (led != led_q);

`ifdef LED_MON_INTERVAL_CHECK_EN
    localparam logic [CNT_W:0] IV_LO = (CNT_W+1)'(STEP_CYCLES - TOL);
    localparam logic [CNT_W:0] IV_HI = (CNT_W+1)'(STEP_CYCLES + TOL);
    logic [CNT_W:0] interval;
    assign interval = {1'b0, cnt_q} + (CNT_W+1)'(1);
`endif

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        dir_valid_d  = dir_valid_q;
        dir_d        = dir_q;
        dir_change_d = 1'b0;
        step_d       = step_q;
        err_hit      = 1'b0;
        err_code_new = ERR_NONE;
        nxt_same     = dir_q ? rotl(prev_q) : rotr(prev_q);
        nxt_opp      = dir_q ? rotr(prev_q) : rotl(prev_q);
        cnt_d        = ev ? '0 : ((cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1));

        case (state_q)
            IDLE: begin
                // Dark or garbled bus is tolerated here: sequencer may be in reset.
                if (is_onehot(led)) begin
                    prev_d  = led;
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (ev) begin
                    prev_d = led;
                    if (led == rotl(prev_q) || led == rotr(prev_q)) begin
                        dir_d       = (led == rotl(prev_q));
                        dir_valid_d = 1'b1;
                        step_d      = 16'd1;
                        state_d     = TRACK;
                    end else begin
                        err_hit      = 1'b1;
                        err_code_new = ERR_PAT;
                        state_d      = IDLE;
                    end
                end
            end
            TRACK: begin
                if (ev) begin
                    if (led == nxt_same) begin
                        prev_d = led;
                        step_d = (step_q == 16'hFFFF) ? step_q : step_q + 16'd1;
`ifdef LED_MON_INTERVAL_CHECK_EN
                        if (interval < IV_LO || interval > IV_HI) begin
                            err_hit      = 1'b1;
                            err_code_new = ERR_TIME;
                        end
`endif
                    end else if (led == nxt_opp) begin
                        prev_d       = led;
                        dir_d        = ~dir_q;
                        dir_change_d = 1'b1;
                        step_d       = 16'd1;
                    end else begin
                        err_hit      = 1'b1;
                        err_code_new = ERR_PAT;
                        dir_valid_d  = 1'b0;
                        step_d       = 16'd0;
                        state_d      = IDLE;
                    end
                end else if (cnt_q == STALL_LAST) begin
                    err_hit      = 1'b1;
                    err_code_new = ERR_STALL;
                    dir_valid_d  = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // An error in the same cycle as err_clr still counts, starting from zero.
        err_pulse_d = err_hit;
        err_code_d  = err_hit ? err_code_new : err_code_q;
        err_flag_d  = err_hit | (err_flag_q & ~mon.err_clr);
        if (err_hit)
            err_count_d = mon.err_clr ? 8'd1
                        : ((err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1);
        else
            err_count_d = mon.err_clr ? 8'd0 : err_count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            led_q        <= '0;
            prev_q       <= '0;
            cnt_q        <= '0;
            dir_valid_q  <= 1'b0;
            dir_q        <= 1'b0;
            dir_change_q <= 1'b0;
            step_q       <= 16'd0;
            err_pulse_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
            err_flag_q   <= 1'b0;
            err_count_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            led_q        <= led;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            dir_valid_q  <= dir_valid_d;
            dir_q        <= dir_d;
            dir_change_q <= dir_change_d;
            step_q       <= step_d;
            err_pulse_q  <= err_pulse_d;
            err_code_q   <= err_code_d;
            err_flag_q   <= err_flag_d;
            err_count_q  <= err_count_d;
        end
    end

    assign mon.dir_valid  = dir_valid_q;
    assign mon.dir        = dir_q;
    assign mon.dir_change = dir_change_q;
    assign mon.step_count = step_q;
    assign mon.err_pulse  = err_pulse_q;
    assign mon.err_code   = err_code_q;
    assign mon.err_flag   = err_flag_q;
    assign mon.err_count  = err_count_q;
endmodule

// File: tb/tb_led_pattern_monitor.sv
// Bench for led_pattern_monitor: directed table, hand-written corner sequences,
// then randomized stimulus against a position-arithmetic reference model.
module tb_led_pattern_monitor;
    localparam int N_LED = 8;
    localparam int STEP  = 16;
    localparam int TOL   = 2;
    localparam int CNT_W = 8;
`ifdef LED_MON_INTERVAL_CHECK_EN
    localparam bit TCHK = 1'b1;
`else
    localparam bit TCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    led_pattern_monitor_if #(.N_LED(N_LED)) ifc();

    led_pattern_monitor #(
        .N_LED(N_LED), .STEP_CYCLES(STEP), .TOL(TOL), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mon(ifc)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int dv, input int dir, input int dch,
                           input int sc, input int ep, input int ec, input int ef, input int en);
        chk({tag, ".dir_valid"},  int'(ifc.dir_valid),  dv);
        chk({tag, ".dir"},        int'(ifc.dir),        dir);
        chk({tag, ".dir_change"}, int'(ifc.dir_change), dch);
        chk({tag, ".step_count"}, int'(ifc.step_count), sc);
        chk({tag, ".err_pulse"},  int'(ifc.err_pulse),  ep);
        chk({tag, ".err_code"},   int'(ifc.err_code),   ec);
        chk({tag, ".err_flag"},   int'(ifc.err_flag),   ef);
        chk({tag, ".err_count"},  int'(ifc.err_count),  en);
    endtask

    // Reference model: positions of the lit LED, distance mod N decides the step kind.
    int         m_mode;      // 0 unanchored, 1 anchored, 2 locked
    logic [7:0] m_led_q, m_prev;
    int         m_since;
    int         m_dv, m_dir, m_dch, m_sc, m_ep, m_ec, m_ef, m_en;

    function automatic int pos(input logic [7:0] v);
        int p = -1;
        int n = 0;
        for (int i = 0; i < 8; i++) if (v[i]) begin n++; p = i; end
        return (n == 1) ? p : -1;
    endfunction

    function automatic int rot_dist(input logic [7:0] a, input logic [7:0] b);
        int pa = pos(a);
        int pb = pos(b);
        int d;
        if (pa < 0 || pb < 0) return 0;
        d = (pb - pa + 8) % 8;
        if (d == 1) return 1;
        if (d == 7) return -1;
        return 0;
    endfunction

    task automatic model_step(input logic [7:0] l, input logic clr, input logic r);
        bit ev;
        int err;
        int d;
        int want;
        if (!r) begin
            m_mode = 0; m_led_q = 8'h00; m_prev = 8'h00; m_since = 0;
            m_dv = 0; m_dir = 0; m_dch = 0; m_sc = 0; m_ep = 0; m_ec = 0; m_ef = 0; m_en = 0;
            return;
        end
        ev    = (l != m_led_q);
        err   = 0;
        m_dch = 0;
        m_ep  = 0;
        if (clr) begin m_ef = 0; m_en = 0; end
        d    = rot_dist(m_prev, l);
        want = (m_dir != 0) ? 1 : -1;
        case (m_mode)
            0: if (pos(l) >= 0) begin m_prev = l; m_mode = 1; end
            1: if (ev) begin
                   if (d != 0) begin
                       m_dir = (d == 1) ? 1 : 0; m_dv = 1; m_sc = 1; m_mode = 2;
                   end else begin
                       err = 1; m_mode = 0;
                   end
                   m_prev = l;
               end
            default: begin
                if (ev) begin
                    if (d == want) begin
                        m_sc = (m_sc < 65535) ? m_sc + 1 : 65535;
                        if (TCHK && (m_since + 1 < STEP - TOL || m_since + 1 > STEP + TOL)) err = 2;
                        m_prev = l;
                    end else if (d == -want) begin
                        m_dir = 1 - m_dir; m_dch = 1; m_sc = 1; m_prev = l;
                    end else begin
                        err = 1; m_dv = 0; m_sc = 0; m_mode = 0;
                    end
                end else if (m_since + 1 >= STEP + TOL + 1) begin
                    err = 3; m_dv = 0; m_mode = 0;
                end
            end
        endcase
        if (err != 0) begin
            m_ep = 1; m_ec = err; m_ef = 1;
            m_en = (m_en < 255) ? m_en + 1 : 255;
        end
        m_since = ev ? 0 : ((m_since < 255) ? m_since + 1 : 255);
        m_led_q = l;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(ifc.led, ifc.err_clr, rst);
        #1;
    endtask

    typedef struct {
        int         gap;
        logic [7:0] led;
        bit         clr;
        bit         rstn;
        int         dv, dir, dch, sc, ep, ec, ef, en;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int gap, input logic [7:0] led, input bit clr, input bit rstn,
                       input int dv, input int dir, input int dch, input int sc,
                       input int ep, input int ec, input int ef, input int en);
        vec_t v;
        v.gap = gap; v.led = led; v.clr = clr; v.rstn = rstn;
        v.dv = dv; v.dir = dir; v.dch = dch; v.sc = sc;
        v.ep = ep; v.ec = ec; v.ef = ef; v.en = en;
        tbl.push_back(v);
    endtask

    initial begin
        logic [7:0] l;
        logic [7:0] cur;
        int         rdir;
        int         cd;
        int         r;

        ifc.led = 8'h00; ifc.err_clr = 1'b0; rst = 1'b0;

        // gap = idle cycles after the checked edge; gap 15 gives a 16-cycle step interval
        add(2,  8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(15, 8'h01, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        l = 8'h01;
        for (int k = 1; k <= 10; k++) begin
            l = {l[6:0], l[7]};
            add(15, l, 0, 1, 1, 1, 0, k, 0, 0, 0, 0);
        end
        add(0,  8'h02, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0);
        add(14, 8'h02, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        add(15, 8'h01, 0, 1, 1, 0, 0, 2, 0, 0, 0, 0);
        add(15, 8'h80, 0, 1, 1, 0, 0, 3, 0, 0, 0, 0);
        add(0,  8'h24, 0, 1, 0, 0, 0, 0, 1, 1, 1, 1);
        add(3,  8'h24, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1);
        add(15, 8'h04, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1);
        add(15, 8'h08, 0, 1, 1, 1, 0, 1, 0, 1, 1, 1);
        add(1,  8'h08, 1, 1, 1, 1, 0, 1, 0, 1, 0, 0);
        add(0,  8'h08, 0, 1, 1, 1, 0, 1, 0, 1, 0, 0);
        add(0,  8'h08, 0, 1, 0, 1, 0, 1, 1, 3, 1, 1);

        foreach (tbl[i]) begin
            rst = tbl[i].rstn; ifc.led = tbl[i].led; ifc.err_clr = tbl[i].clr;
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].dv, tbl[i].dir, tbl[i].dch, tbl[i].sc,
                    tbl[i].ep, tbl[i].ec, tbl[i].ef, tbl[i].en);
            ifc.err_clr = 1'b0;
            repeat (tbl[i].gap) tick();
        end

        // Build err_count up to 5 with SYNC pattern errors, then error plus clear together
        tick();
        for (int k = 0; k < 4; k++) begin
            ifc.led = 8'h03; tick();
            ifc.led = 8'h08; tick();
        end
        chk("cnt5.err_count", int'(ifc.err_count), 5);
        ifc.led = 8'h03; ifc.err_clr = 1'b1; tick();
        ifc.err_clr = 1'b0;
        chk("clr_vs_err.err_count", int'(ifc.err_count), 1);
        chk("clr_vs_err.err_flag",  int'(ifc.err_flag),  1);
        chk("clr_vs_err.err_pulse", int'(ifc.err_pulse), 1);
        chk("clr_vs_err.err_code",  int'(ifc.err_code),  1);

        // Interval boundaries: 12 (short), 14 (lower edge), 19 (just past upper edge)
        ifc.led = 8'h01; tick(); repeat (15) tick();
        ifc.led = 8'h02; tick();
        chk("iv.lock.sc", int'(ifc.step_count), 1);
        repeat (15) tick();
        ifc.led = 8'h04; tick();
        chk("iv16.err_pulse", int'(ifc.err_pulse), 0);
        repeat (11) tick();
        ifc.led = 8'h08; tick();
        chk("iv12.err_pulse", int'(ifc.err_pulse), TCHK ? 1 : 0);
        chk("iv12.err_code",  int'(ifc.err_code),  TCHK ? 2 : 1);
        chk("iv12.dir_valid", int'(ifc.dir_valid), 1);
        chk("iv12.step_count", int'(ifc.step_count), 3);
        repeat (13) tick();
        ifc.led = 8'h10; tick();
        chk("iv14.err_pulse", int'(ifc.err_pulse), 0);
        chk("iv14.step_count", int'(ifc.step_count), 4);
        repeat (18) tick();
        ifc.led = 8'h20; tick();
        chk("iv19.err_pulse", int'(ifc.err_pulse), TCHK ? 1 : 0);
        chk("iv19.dir_valid", int'(ifc.dir_valid), 1);
        chk("iv19.err_count", int'(ifc.err_count), TCHK ? 3 : 1);

        // Reset while locked
        rst = 1'b0; tick();
        chk_all("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;

        // Randomized phase against the model
        rst = 1'b0; ifc.led = 8'h00; tick(); tick(); rst = 1'b1;
        cur = 8'h01; rdir = 1; cd = 0;
        for (int i = 0; i < 4000; i++) begin
            if (cd == 0) begin
                r = $urandom_range(0, 99);
                if (r < 78) begin
                    if (r >= 65) rdir = 1 - rdir;
                    if (pos(cur) < 0) cur = 8'(1 << $urandom_range(0, 7));
                    else cur = (rdir != 0) ? {cur[6:0], cur[7]} : {cur[0], cur[7:1]};
                end else if (r < 88) begin
                    cur = 8'($urandom);
                end else if (r < 92) begin
                    cur = 8'h00;
                end
                cd = (r >= 95) ? 24 : $urandom_range(11, 20);
            end else begin
                cd--;
            end
            ifc.led     = cur;
            ifc.err_clr = ($urandom_range(0, 59) == 0);
            rst         = ($urandom_range(0, 799) != 0);
            tick();
            chk_all("rnd", m_dv, m_dir, m_dch, m_sc, m_ep, m_ec, m_ef, m_en);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
